// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and pointer helper for the 16-way arbiter.
package mux_arb_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Next round-robin position; 4-bit overflow gives the 15 -> 0 wrap.
    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        return p + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux16x1.sv
// Single-bit 16:1 select; one copy per data bit shares the lane select.
module mux16x1
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  d,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] ofs;

    // Rotate so that bit 0 is the lane at ptr; 4-bit index sum wraps mod 16.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot[k] = req[ptr + SEL_W'(k)];
        end
    end

    // Lowest set bit of the rotated vector, mapped back to a lane number.
    always_comb begin
        ofs = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) ofs = SEL_W'(k);
        end
        found = |rot;
        idx   = ptr + ofs;
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 data mux; captures the winner's data
// and holds it until the downstream valid/ready handshake completes.
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW        = 1,
    parameter int RESET_PTR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        req,
    input  logic [16*DW-1:0]   din,
    output logic [15:0]        gnt,
    output logic [3:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [3:0]         out_src
);

    arb_state_t           state;
    logic [SEL_W-1:0]     ptr;
    logic                 pick_found;
    logic [SEL_W-1:0]     pick_idx;
    logic [DW-1:0][NREQ-1:0] col;
    logic [DW-1:0]        mux_q;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The mux is steered by the live pick so data is captured on the grant edge.
    for (genvar b = 0; b < DW; b++) begin : g_bit
        for (genvar i = 0; i < NREQ; i++) begin : g_lane
            assign col[b][i] = din[i*DW + b];
        end
        mux16x1 u_mux (
            .d (col[b]),
            .s (pick_idx),
            .y (mux_q[b])
        );
    end

    // Arbitration FSM with all outputs registered; HOLD ignores req/din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= SEL_W'(RESET_PTR);
            gnt       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        sel       <= pick_idx;
                        out_src   <= pick_idx;
                        gnt       <= NREQ'(1) << pick_idx;
                        out_data  <= mux_q;
                        out_valid <= 1'b1;
                        state     <= ARB_HOLD;
                    end else begin
                        gnt       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                ARB_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gnt       <= '0;
                        ptr       <= ptr_inc(sel);
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with a per-cycle reference model.
module tb_mux16_rr_arbiter;

    localparam int DW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       req = '0;
    logic [16*DW-1:0]  din = '0;
    logic [15:0]       gnt;
    logic [3:0]        sel;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [3:0]        out_src;

    int tests = 0;
    int fails = 0;

    mux16_rr_arbiter #(.DW(DW), .RESET_PTR(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: "busy with lane m_src" or "free, search from m_ptr".
    bit            m_valid;
    int            m_ptr;
    int            m_src;
    logic [DW-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_ptr = 0; m_src = 0; m_data = '0;
        end else if (!m_valid) begin
            for (int k = 0; k < 16; k++) begin
                int j;
                j = (m_ptr + k) % 16;
                if (!m_valid && req[j]) begin
                    m_valid = 1;
                    m_src   = j;
                    m_data  = din[j*DW +: DW];
                end
            end
        end else if (out_ready) begin
            m_valid = 0;
            m_ptr   = (m_src + 1) % 16;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_valid", out_valid, m_valid);
        chk("m_gnt", gnt, m_valid ? (32'h1 << m_src) : 32'h0);
        chk("m_sel", sel, m_src);
        chk("m_src", out_src, m_src);
        chk("m_data", out_data, m_data);
    end

    task automatic wait_valid(output int src, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 50);
        chk("wait_valid_timeout", out_valid, 1'b1);
        src = out_src;
    endtask

    initial begin
        int src, cyc;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;

        // Single request, lane 4; then pointer moves to 5 so lane 0 beats lane 4
        out_ready = 1'b1;
        req = 16'h0010;
        din[4*DW +: DW] = 2'b11;
        wait_valid(src, cyc);
        chk("single_src", src, 4);
        chk("single_gnt", gnt, 16'h0010);
        chk("single_data", out_data, 2'b11);
        chk("single_lat", cyc, 1);
        req = 16'h0011;
        wait_valid(src, cyc);
        chk("ptr5_src", src, 0);
        req = '0;
        din = '0;
        repeat (2) @(negedge clk);

        // Fresh reset, then all lanes requesting
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            wait_valid(src, cyc);
            chk("rr_src", src, k % 16);
            if (k > 0) chk("rr_gap", cyc, 2);
        end

        // Wrap: serve lane 14 so ptr=15, then only lanes 15 and 0
        req = 16'h4000;
        wait_valid(src, cyc);
        chk("wrap_pre", src, 14);
        req = 16'h8001;
        wait_valid(src, cyc); chk("wrap_a", src, 15);
        wait_valid(src, cyc); chk("wrap_b", src, 0);
        wait_valid(src, cyc); chk("wrap_c", src, 15);
        req = '0;
        repeat (2) @(negedge clk);

        // Backpressure on lane 7 while inputs churn
        out_ready = 1'b0;
        req = 16'h0080;
        din[7*DW +: DW] = 2'b01;
        wait_valid(src, cyc);
        chk("bp_src", src, 7);
        for (int k = 0; k < 5; k++) begin
            din[7*DW +: DW] = ~din[7*DW +: DW];
            req = req ^ 16'h0104;
            @(negedge clk);
            chk("bp_data", out_data, 2'b01);
            chk("bp_gnt", gnt, 16'h0080);
            chk("bp_sel", sel, 7);
        end
        req = '0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_done", out_valid, 0);
        end
        din = '0;

        // Late drop of req[3] during HOLD
        out_ready = 1'b0;
        req = 16'h0008;
        din[3*DW +: DW] = 2'b10;
        wait_valid(src, cyc);
        chk("drop_src", src, 3);
        req = '0;
        din[3*DW +: DW] = 2'b01;
        repeat (2) @(negedge clk);
        chk("drop_data", out_data, 2'b10);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("drop_nogrant", out_valid, 0);
        end
        din = '0;

        // Asynchronous reset in the middle of HOLD
        out_ready = 1'b0;
        req = 16'h0002;
        din[1*DW +: DW] = 2'b11;
        wait_valid(src, cyc);
        chk("ar_data_pre", out_data, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_gnt", gnt, 0);
        chk("ar_data", out_data, 0);
        @(negedge clk);
        din = '0;
        din[0 +: DW] = 2'b01;
        req = 16'h0001;
        out_ready = 1'b1;
        rst_n = 1'b1;
        wait_valid(src, cyc);
        chk("ar_after_src", src, 0);
        chk("ar_after_data", out_data, 2'b01);
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 16:1 data mux between 16 requesters. It picks one requester, drives the mux select and a one-hot grant, and captures the selected data into an output register. It presents the data downstream with a valid/ready handshake. The block sits between the 16 producer lanes and the single shared consumer, in front of the gate-level 16:1 mux datapath.

Parameters:
DW, 1, data width per requester lane (1 matches the existing 16x1 mux; >1 replicates the select per bit)
RESET_PTR, 0, requester index that has highest priority after reset (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  16  per-requester request; bit i = lane i has data
din  input  16*DW  lane data, lane i at din[i*DW +: DW]
gnt  output  16  one-hot grant; held for the whole transfer
sel  output  4  mux select = index of granted lane
out_valid  output  1  out_data/out_src hold a transfer
out_ready  input  1  downstream accepts when high with out_valid
out_data  output  DW  captured data of granted lane
out_src  output  4  index of the lane that produced out_data

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=ARB_IDLE, ptr=RESET_PTR.
  - gnt=0, sel=0, out_valid=0, out_data=0, out_src=0.
  - Any in-flight transfer is dropped with no handshake.
- State ARB_IDLE:
  - Combinational pick: the first i with req[i]=1, searching ptr, ptr+1, ... ,15, 0, ... ,ptr-1 (mod 16).
  - If found, at the next edge register:
    - sel=i, out_src=i, gnt=1<<i.
    - out_data=din lane i, taken through the 16:1 select at that edge.
    - out_valid=1; go to ARB_HOLD.
  - If none found, stay in ARB_IDLE with all outputs unchanged except gnt=0 and out_valid=0.
- State ARB_HOLD:
  - out_valid, gnt, sel, out_src and out_data are stable; changes on din or req are ignored.
  - Handshake is out_valid & out_ready at a rising edge. On handshake:
    - out_valid=0, gnt=0.
    - ptr=(sel+1) mod 16, so 15 wraps to 0.
    - Go to ARB_IDLE.
  - Without out_ready, stay in ARB_HOLD indefinitely; there is no timeout.
- Latency and throughput:
  - From req sampled in ARB_IDLE to out_valid high is 1 cycle.
  - Minimum spacing is 2 cycles per transfer, due to one IDLE bubble after each handshake.
- Requester protocol:
  - Lane i sees gnt[i]&out_ready and must drop req[i] in the following cycle unless it has another item.
  - A lane with continuous req is re-served only after every other active lane, so the scheme is starvation-free.
- Boundary conditions:
  - req[i] dropping during HOLD: the captured data still completes the transfer.
  - All 16 requesting: lanes are served in strict order ptr, ptr+1, ...
  - Only the lane at ptr-1 requesting: it is served again; the wrap search reaches it last.
  - sel stays at its last value in ARB_IDLE; it only updates on grant.
  - Reset asserted mid-HOLD: outputs clear immediately (asynchronous), with no handshake.
- Data path width: DW independent copies of the 16:1 select share sel. No arithmetic other than the 4-bit mod-16 pointer increment, which uses natural overflow.

Decomposition:
- Package mux_arb_pkg holds:
  - NREQ=16 and SEL_W=4.
  - State enum arb_state_t {ARB_IDLE, ARB_HOLD}.
  - Function for mod-NREQ increment.
- Sub-module rr_pick16: a combinational picker.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: found, idx[3:0].
  - Implementation: rotate req right by ptr, find first one, add ptr back mod 16.
- The 16:1 data select reuses the team's gate-level 16:1 mux per bit, driven by the picker idx.

Test Plan:
- Reset: rst_n=0 mid-HOLD with out_valid=1 -> gnt=0, out_valid=0, out_data=0 immediately. After release, req=16'h0001 gives out_src=0.
- Single request: req=16'h0010, din lane4=1, out_ready=1 -> out_valid rises 1 cycle later with out_src=4, gnt=16'h0010, out_data=1. Handshake that cycle, then ptr=5.
- Round-robin: req=16'hFFFF held, out_ready=1 -> out_src sequence 0,1,2,...,15,0 with one idle cycle between grants.
- Wrap: ptr=15, req=16'h8001 -> lane15 granted first, then lane0, then lane15 again.
- Backpressure: grant lane 7 with out_ready=0 for 5 cycles while din lane7 toggles and req changes -> out_data, gnt and sel remain stable. out_ready=1 completes exactly one transfer.
- Late drop: req[3] drops in the cycle after grant -> the transfer still completes with the captured value, and no second grant is issued to lane 3.
